chunked_serial_adder: RTL and testbench

// Multi-cycle, parametrised add/subtract unit that processes a WIDTH-bit operand pair CHUNK bits per clock.
// A registered carry links each chunk to the next, so the gate-level adder logic is reused for every chunk.

---
 rtl/chunked_serial_adder.sv | 123 ++++++++++++
 tb/tb_chunked_serial_adder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: WIDTH-bit add/subtract that consumes CHUNK bits per
// clock. A registered carry links each chunk to the next one, so a single
// CHUNK-bit adder is reused for the whole operand.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | adding one chunk per cycle, low chunk first
// DONE  | one-cycle result strobe; a new start is also accepted here
module chunked_serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NCH - 1);

  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("chunked_serial_adder: WIDTH must be a nonzero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  // Operands are shifted right each RUN cycle, so the active chunk is
  // always in the low CHUNK bits; on the last chunk the operand sign bits
  // sit at bit CHUNK-1.
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CW-1:0]    idx;
  logic [WIDTH-1:0] partial;

  logic [CHUNK:0]         chunk_add;
  logic [WIDTH+CHUNK-1:0] partial_cat;
  logic [WIDTH-1:0]       partial_next;
  logic                   ovf_next;

  // One chunk of the addition plus the partial-sum shift-in from the top.
  always_comb begin
    chunk_add    = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, carry};
    partial_cat  = {chunk_add[CHUNK-1:0], partial};
    partial_next = partial_cat[WIDTH+CHUNK-1:CHUNK];
    ovf_next     = (op_a[CHUNK-1] == op_b[CHUNK-1])
                && (chunk_add[CHUNK-1] != op_a[CHUNK-1]);
  end

  // Control FSM, datapath registers and registered result/handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      partial <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            // Subtract is a + ~b + 1; the +1 enters as the initial carry,
            // which also keeps a previous cout from leaking into chunk 0.
            carry <= sub;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          op_a    <= op_a >> CHUNK;
          op_b    <= op_b >> CHUNK;
          carry   <= chunk_add[CHUNK];
          partial <= partial_next;
          idx     <= idx + CW'(1);
          if (idx == LAST_IDX) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= partial_next;
            cout  <= chunk_add[CHUNK];
            ovf   <= ovf_next;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed bench for chunked_serial_adder: three instances (8/1, 16/4, 4/2)
// share one clock; every scenario is a task with inline checks.
module tb_chunked_serial_adder;

  logic clk;
  logic rst_n;

  logic       s8_start, s8_sub, s8_busy, s8_done, s8_cout, s8_ovf;
  logic [7:0] s8_a, s8_b, s8_sum;

  logic        s16_start, s16_sub, s16_busy, s16_done, s16_cout, s16_ovf;
  logic [15:0] s16_a, s16_b, s16_sum;

  logic       s4_start, s4_sub, s4_busy, s4_done, s4_cout, s4_ovf;
  logic [3:0] s4_a, s4_b, s4_sum;

  int n_checks;
  int n_fail;

  chunked_serial_adder #(.WIDTH(8), .CHUNK(1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .sub(s8_sub), .a(s8_a), .b(s8_b),
    .busy(s8_busy), .done(s8_done), .sum(s8_sum), .cout(s8_cout), .ovf(s8_ovf));

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) u_w16 (
    .clk(clk), .rst_n(rst_n), .start(s16_start), .sub(s16_sub), .a(s16_a), .b(s16_b),
    .busy(s16_busy), .done(s16_done), .sum(s16_sum), .cout(s16_cout), .ovf(s16_ovf));

  chunked_serial_adder #(.WIDTH(4), .CHUNK(2)) u_w4 (
    .clk(clk), .rst_n(rst_n), .start(s4_start), .sub(s4_sub), .a(s4_a), .b(s4_b),
    .busy(s4_busy), .done(s4_done), .sum(s4_sum), .cout(s4_cout), .ovf(s4_ovf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one 8-bit op and wait (bounded) for done; returns at the negedge
  // of the DONE cycle. held=0 if sum moved while busy.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                      output int edges, output int busy_cyc, output bit held);
    logic [7:0] sum_before;
    @(negedge clk);
    s8_a = av; s8_b = bv; s8_sub = sv; s8_start = 1'b1;
    sum_before = s8_sum;
    held = 1'b1; edges = 0; busy_cyc = 0;
    do begin
      @(posedge clk); edges++;
      @(negedge clk); s8_start = 1'b0;
      if (s8_busy) begin
        busy_cyc++;
        if (s8_sum !== sum_before) held = 1'b0;
      end
    end while (!s8_done && edges < 40);
  endtask

  task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                       output int edges);
    @(negedge clk);
    s16_a = av; s16_b = bv; s16_sub = sv; s16_start = 1'b1;
    edges = 0;
    do begin
      @(posedge clk); edges++;
      @(negedge clk); s16_start = 1'b0;
    end while (!s16_done && edges < 40);
  endtask

  task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic sv,
                      output int edges);
    @(negedge clk);
    s4_a = av; s4_b = bv; s4_sub = sv; s4_start = 1'b1;
    edges = 0;
    do begin
      @(posedge clk); edges++;
      @(negedge clk); s4_start = 1'b0;
    end while (!s4_done && edges < 40);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s8_start = 0; s8_sub = 0; s8_a = '0; s8_b = '0;
    s16_start = 0; s16_sub = 0; s16_a = '0; s16_b = '0;
    s4_start = 0; s4_sub = 0; s4_a = '0; s4_b = '0;
    repeat (3) @(negedge clk);
    n_checks++; if ({s8_busy, s8_done, s8_cout, s8_ovf} !== 4'b0000) begin n_fail++; $display("FAIL reset w8 flags: got %b want 0000", {s8_busy, s8_done, s8_cout, s8_ovf}); end
    n_checks++; if (s8_sum !== 8'h00) begin n_fail++; $display("FAIL reset w8 sum: got %h want 00", s8_sum); end
    n_checks++; if ({s16_busy, s16_done, s16_cout, s16_ovf} !== 4'b0000) begin n_fail++; $display("FAIL reset w16 flags: got %b want 0000", {s16_busy, s16_done, s16_cout, s16_ovf}); end
    n_checks++; if (s16_sum !== 16'h0000) begin n_fail++; $display("FAIL reset w16 sum: got %h want 0000", s16_sum); end
    n_checks++; if ({s4_busy, s4_done, s4_cout, s4_ovf, s4_sum} !== 8'h00) begin n_fail++; $display("FAIL reset w4 outputs: got %h want 00", {s4_busy, s4_done, s4_cout, s4_ovf, s4_sum}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_basic();
    int e, bc; bit h;
    run8(8'h3C, 8'h0F, 1'b0, e, bc, h);
    n_checks++; if (s8_done !== 1'b1) begin n_fail++; $display("FAIL basic timeout: done=%b after %0d edges", s8_done, e); end
    n_checks++; if (e != 9) begin n_fail++; $display("FAIL basic latency: got %0d edges want 9", e); end
    n_checks++; if (bc != 8) begin n_fail++; $display("FAIL basic busy cycles: got %0d want 8", bc); end
    n_checks++; if (!h) begin n_fail++; $display("FAIL basic sum hold during RUN: got changed want held"); end
    n_checks++; if (s8_sum !== 8'h4B) begin n_fail++; $display("FAIL basic sum: got %h want 4B", s8_sum); end
    n_checks++; if ({s8_cout, s8_ovf} !== 2'b00) begin n_fail++; $display("FAIL basic cout/ovf: got %b want 00", {s8_cout, s8_ovf}); end
    @(negedge clk);
    n_checks++; if (s8_done !== 1'b0) begin n_fail++; $display("FAIL basic done pulse width: got %b want 0", s8_done); end
    n_checks++; if (s8_sum !== 8'h4B) begin n_fail++; $display("FAIL basic sum hold after done: got %h want 4B", s8_sum); end
  endtask

  task automatic test_add_edges();
    int e, bc; bit h;
    run8(8'hFF, 8'h01, 1'b0, e, bc, h);
    n_checks++; if ({s8_sum, s8_cout, s8_ovf} !== {8'h00, 1'b1, 1'b0}) begin n_fail++; $display("FAIL add FF+01: got sum=%h cout=%b ovf=%b want 00/1/0", s8_sum, s8_cout, s8_ovf); end
    run8(8'h7F, 8'h01, 1'b0, e, bc, h);
    n_checks++; if ({s8_sum, s8_cout, s8_ovf} !== {8'h80, 1'b0, 1'b1}) begin n_fail++; $display("FAIL add 7F+01: got sum=%h cout=%b ovf=%b want 80/0/1", s8_sum, s8_cout, s8_ovf); end
    run8(8'hC0, 8'h80, 1'b0, e, bc, h);
    n_checks++; if ({s8_sum, s8_cout, s8_ovf} !== {8'h40, 1'b1, 1'b1}) begin n_fail++; $display("FAIL add C0+80: got sum=%h cout=%b ovf=%b want 40/1/1", s8_sum, s8_cout, s8_ovf); end
  endtask

  task automatic test_sub();
    int e, bc; bit h;
    run8(8'h05, 8'h07, 1'b1, e, bc, h);
    n_checks++; if ({s8_sum, s8_cout, s8_ovf} !== {8'hFE, 1'b0, 1'b0}) begin n_fail++; $display("FAIL sub 05-07: got sum=%h cout=%b ovf=%b want FE/0/0", s8_sum, s8_cout, s8_ovf); end
    run8(8'h80, 8'h01, 1'b1, e, bc, h);
    n_checks++; if ({s8_sum, s8_cout, s8_ovf} !== {8'h7F, 1'b1, 1'b1}) begin n_fail++; $display("FAIL sub 80-01: got sum=%h cout=%b ovf=%b want 7F/1/1", s8_sum, s8_cout, s8_ovf); end
    run8(8'h42, 8'h42, 1'b1, e, bc, h);
    n_checks++; if ({s8_sum, s8_cout, s8_ovf} !== {8'h00, 1'b1, 1'b0}) begin n_fail++; $display("FAIL sub 42-42: got sum=%h cout=%b ovf=%b want 00/1/0", s8_sum, s8_cout, s8_ovf); end
  endtask

  task automatic test_reset_mid_run();
    int dones;
    // Previous result is 00/1/0; make it 7F/1/1 so every output must drop.
    begin
      int e, bc; bit h;
      run8(8'h80, 8'h01, 1'b1, e, bc, h);
    end
    @(negedge clk);
    s8_a = 8'h11; s8_b = 8'h22; s8_sub = 1'b0; s8_start = 1'b1;
    @(posedge clk);
    @(negedge clk); s8_start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if ({s8_busy, s8_done, s8_cout, s8_ovf} !== 4'b0000) begin n_fail++; $display("FAIL midrun reset flags: got %b want 0000", {s8_busy, s8_done, s8_cout, s8_ovf}); end
    n_checks++; if (s8_sum !== 8'h00) begin n_fail++; $display("FAIL midrun reset sum: got %h want 00", s8_sum); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (s8_done) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL midrun reset stray done: got %0d pulses want 0", dones); end
  endtask

  task automatic test_ignore_start();
    int dones, done_edge, edges;
    logic [7:0] res;
    @(negedge clk);
    s8_a = 8'h10; s8_b = 8'h20; s8_sub = 1'b0; s8_start = 1'b1;
    dones = 0; done_edge = 0; edges = 0; res = 8'h00;
    repeat (20) begin
      @(posedge clk); edges++;
      @(negedge clk);
      s8_start = (edges == 3);
      if (edges == 3) begin s8_a = 8'h55; s8_b = 8'h66; s8_sub = 1'b1; end
      if (s8_done) begin dones++; done_edge = edges; res = s8_sum; end
    end
    s8_start = 1'b0;
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL ignore start done count: got %0d want 1", dones); end
    n_checks++; if (done_edge != 9) begin n_fail++; $display("FAIL ignore start done edge: got %0d want 9", done_edge); end
    n_checks++; if (res !== 8'h30) begin n_fail++; $display("FAIL ignore start result: got %h want 30", res); end
  endtask

  task automatic test_back_to_back();
    int dones, edges, last_edge, bad_gap, bad_sum, first_edge, waited;
    @(negedge clk);
    s8_a = 8'h01; s8_b = 8'h02; s8_sub = 1'b0; s8_start = 1'b1;
    dones = 0; edges = 0; last_edge = 0; bad_gap = 0; bad_sum = 0; first_edge = 0;
    repeat (27) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (s8_done) begin
        dones++;
        if (dones == 1) first_edge = edges;
        else if (edges - last_edge != 9) bad_gap++;
        last_edge = edges;
        if (s8_sum !== 8'h03) bad_sum++;
      end
    end
    s8_start = 1'b0;
    n_checks++; if (dones != 3) begin n_fail++; $display("FAIL back_to_back done count: got %0d want 3", dones); end
    n_checks++; if (first_edge != 9) begin n_fail++; $display("FAIL back_to_back first done edge: got %0d want 9", first_edge); end
    n_checks++; if (bad_gap != 0) begin n_fail++; $display("FAIL back_to_back spacing: got %0d bad gaps want 0", bad_gap); end
    n_checks++; if (bad_sum != 0) begin n_fail++; $display("FAIL back_to_back sum: got %0d wrong results want 0", bad_sum); end
    waited = 0;
    while ((s8_busy || s8_done) && waited < 20) begin @(negedge clk); waited++; end
    n_checks++; if (s8_busy !== 1'b0) begin n_fail++; $display("FAIL back_to_back drain: busy=%b want 0", s8_busy); end
  endtask

  task automatic test_wide16();
    int e;
    run16(16'hFFFF, 16'h0001, 1'b0, e);
    n_checks++; if (e != 5) begin n_fail++; $display("FAIL w16 latency: got %0d edges want 5", e); end
    n_checks++; if ({s16_sum, s16_cout, s16_ovf} !== {16'h0000, 1'b1, 1'b0}) begin n_fail++; $display("FAIL w16 FFFF+0001: got sum=%h cout=%b ovf=%b want 0000/1/0", s16_sum, s16_cout, s16_ovf); end
    run16(16'h1234, 16'h0234, 1'b1, e);
    n_checks++; if ({s16_sum, s16_cout, s16_ovf} !== {16'h1000, 1'b1, 1'b0}) begin n_fail++; $display("FAIL w16 1234-0234: got sum=%h cout=%b ovf=%b want 1000/1/0", s16_sum, s16_cout, s16_ovf); end
    run16(16'h7000, 16'h1000, 1'b0, e);
    n_checks++; if ({s16_sum, s16_cout, s16_ovf} !== {16'h8000, 1'b0, 1'b1}) begin n_fail++; $display("FAIL w16 7000+1000: got sum=%h cout=%b ovf=%b want 8000/0/1", s16_sum, s16_cout, s16_ovf); end
  endtask

  task automatic test_exhaustive4();
    int e, full;
    logic [3:0] av, bv, exp_sum;
    logic exp_cout, exp_ovf;
    for (int sv = 0; sv < 2; sv++) begin
      for (int ai = 0; ai < 16; ai++) begin
        for (int bi = 0; bi < 16; bi++) begin
          av = ai[3:0]; bv = bi[3:0];
          full = (sv != 0) ? (ai - bi + 16) : (ai + bi);
          exp_sum  = full[3:0];
          exp_cout = full[4];
          if (sv != 0) exp_ovf = (av[3] != bv[3]) && (exp_sum[3] != av[3]);
          else         exp_ovf = (av[3] == bv[3]) && (exp_sum[3] != av[3]);
          run4(av, bv, sv[0], e);
          n_checks++;
          if (e != 3 || {s4_sum, s4_cout, s4_ovf} !== {exp_sum, exp_cout, exp_ovf}) begin
            n_fail++;
            $display("FAIL w4 a=%h b=%h sub=%0d: got sum=%h cout=%b ovf=%b edges=%0d want %h/%b/%b edges=3",
                     av, bv, sv, s4_sum, s4_cout, s4_ovf, e, exp_sum, exp_cout, exp_ovf);
          end
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_add_basic();
    test_add_edges();
    test_sub();
    test_reset_mid_run();
    test_ignore_start();
    test_back_to_back();
    test_wide16();
    test_exhaustive4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
